// File: rtl/fpdiv_seq_ctrl.sv
// Goldschmidt divider control sequencer: start/busy/done handshake driving the
// fpdiv operand selects and register enables, one Moore state per datapath cycle.
module fpdiv_seq_ctrl #(
  parameter int ITERATIONS = 6,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [1:0]    sel_mux4,
  output logic [1:0]    sel_mux3,
  output logic          en_a,
  output logic          en_b,
  output logic          en_rem,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_NUM  = 3'd1;
  localparam logic [2:0] S_DEN  = 3'd2;
  localparam logic [2:0] S_ITA  = 3'd3;
  localparam logic [2:0] S_ITB  = 3'd4;
  localparam logic [2:0] S_REM  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [CW-1:0] ITER_ZERO = '0;
  localparam logic [CW-1:0] ITER_ONE  = CW'(1);
  localparam logic [CW-1:0] ITER_LAST = CW'(ITERATIONS);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic [CW-1:0] iter_inc;
  logic          in_run;

  assign iter_inc = iter_q + ITER_ONE;
  assign in_run   = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_NUM;
          iter_d  = ITER_ONE;
        end
      end
      S_NUM: state_d = S_DEN;
      S_DEN: begin
        iter_d  = ITER_ONE;
        state_d = (ITERATIONS > 1) ? S_ITA : S_REM;
      end
      S_ITA: state_d = S_ITB;
      S_ITB: begin
        iter_d  = iter_inc;
        state_d = (iter_inc < ITER_LAST) ? S_ITA : S_REM;
      end
      S_REM: begin
        state_d = S_DONE;
        iter_d  = ITER_ZERO;
      end
      S_DONE: begin
        if (start) begin
          state_d = S_NUM;
          iter_d  = ITER_ONE;
        end else begin
          state_d = S_IDLE;
          iter_d  = ITER_ZERO;
        end
      end
      default: begin
        state_d = S_IDLE;
        iter_d  = ITER_ZERO;
      end
    endcase
    if (in_run && abort) begin
      state_d = S_IDLE;
      iter_d  = ITER_ZERO;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= ITER_ZERO;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // The counter holds completed iterations; during an ITA/ITB pair the
  // iteration in progress is one beyond it, so the reported index runs 2..N.
  always_comb begin
    sel_mux4 = 2'b00;
    sel_mux3 = 2'b00;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_rem   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    iter     = iter_q;
    case (state_q)
      S_NUM: begin
        en_a = 1'b1;
        busy = 1'b1;
      end
      S_DEN: begin
        sel_mux4 = 2'b01;
        en_b     = 1'b1;
        busy     = 1'b1;
      end
      S_ITA: begin
        sel_mux4 = 2'b10;
        sel_mux3 = 2'b01;
        en_a     = 1'b1;
        busy     = 1'b1;
        iter     = iter_inc;
      end
      S_ITB: begin
        sel_mux4 = 2'b11;
        sel_mux3 = 2'b01;
        en_b     = 1'b1;
        busy     = 1'b1;
        iter     = iter_inc;
      end
      S_REM: begin
        sel_mux4 = 2'b10;
        sel_mux3 = 2'b10;
        en_rem   = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpdiv_seq_ctrl.sv
// Scoreboard bench for fpdiv_seq_ctrl: a default (6-iteration) and a minimum
// (1-iteration) instance, expected per-cycle output vectors queued at stimulus time.
module tb_fpdiv_seq_ctrl;

  typedef struct packed {
    int unsigned cyc;
    logic [12:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       start6 = 1'b0, abort6 = 1'b0;
  logic [1:0] m4_6, m3_6;
  logic       ea_6, eb_6, er_6, busy_6, done_6;
  logic [3:0] iter_6;

  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [1:0] m4_1, m3_1;
  logic       ea_1, eb_1, er_1, busy_1, done_1;
  logic [3:0] iter_1;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t q6[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fpdiv_seq_ctrl #(.ITERATIONS(6), .CW(4)) dut6 (
    .clk(clk), .reset(reset), .start(start6), .abort(abort6),
    .sel_mux4(m4_6), .sel_mux3(m3_6), .en_a(ea_6), .en_b(eb_6), .en_rem(er_6),
    .busy(busy_6), .done(done_6), .iter(iter_6)
  );

  fpdiv_seq_ctrl #(.ITERATIONS(1), .CW(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .sel_mux4(m4_1), .sel_mux3(m3_1), .en_a(ea_1), .en_b(eb_1), .en_rem(er_1),
    .busy(busy_1), .done(done_1), .iter(iter_1)
  );

  wire [12:0] vec6 = {m4_6, m3_6, ea_6, eb_6, er_6, busy_6, done_6, iter_6};
  wire [12:0] vec1 = {m4_1, m3_1, ea_1, eb_1, er_1, busy_1, done_1, iter_1};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic [1:0] m4, input logic [1:0] m3,
                                     input logic a, input logic b, input logic r,
                                     input logic bsy, input logic dn, input int it);
    logic [3:0] it4;
    it4 = it[3:0];
    return {m4, m3, a, b, r, bsy, dn, it4};
  endfunction

  task automatic push(input bit which, input int unsigned c, input logic [12:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    if (which) q1.push_back(e);
    else       q6.push_back(e);
  endtask

  // Expected vectors for one full run whose NUM cycle is base.
  task automatic push_run(input bit which, input int n, input int unsigned base);
    int unsigned c;
    c = base;
    push(which, c, mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 1)); c++;
    push(which, c, mk(2'b01, 2'b00, 0, 1, 0, 1, 0, 1)); c++;
    for (int p = 2; p <= n; p++) begin
      push(which, c, mk(2'b10, 2'b01, 1, 0, 0, 1, 0, p)); c++;
      push(which, c, mk(2'b11, 2'b01, 0, 1, 0, 1, 0, p)); c++;
    end
    push(which, c, mk(2'b10, 2'b10, 0, 0, 1, 1, 0, n)); c++;
    push(which, c, mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
  endtask

  task automatic drop_after(input int unsigned last_cyc);
    while (q6.size() > 0 && q6[$].cyc > last_cyc) void'(q6.pop_back());
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q6.size() > 0 && q6[0].cyc == cyc) begin
      e = q6.pop_front();
      check("dut6_seq", {3'b0, vec6}, {3'b0, e.v});
      if (e.v[4]) $display("dut6 run complete at cycle %0d, iter=%0d", cyc, iter_6);
    end else begin
      check("dut6_idle", {3'b0, vec6}, 16'h0);
    end
    check("dut6_en_excl", 16'($countones({ea_6, eb_6, er_6}) <= 1), 16'd1);
    check("dut6_iter_max", 16'(iter_6 <= 4'd6), 16'd1);

    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      check("dut1_seq", {3'b0, vec1}, {3'b0, e.v});
      if (e.v[4]) $display("dut1 run complete at cycle %0d, iter=%0d", cyc, iter_1);
    end else begin
      check("dut1_idle", {3'b0, vec1}, 16'h0);
    end
    check("dut1_no_ita_itb", 16'(m4_1 == 2'b11 || m3_1 == 2'b01), 16'd0);
    check("dut1_en_excl", 16'($countones({ea_1, eb_1, er_1}) <= 1), 16'd1);
    check("dut1_iter_max", 16'(iter_1 <= 4'd1), 16'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) tick();
  endtask

  initial begin
    int unsigned base;

    #1 reset = 1'b1;
    #1;
    check("reset_async_dut6", {3'b0, vec6}, 16'h0);
    check("reset_async_dut1", {3'b0, vec1}, 16'h0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();

    // Default run on both instances, plus an ignored start at run cycle 5 on dut6.
    base = cyc + 1;
    start6 = 1'b1; start1 = 1'b1;
    push_run(0, 6, base);
    push_run(1, 1, base);
    tick();
    start6 = 1'b0; start1 = 1'b0;
    wait_cyc(base + 4);
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    wait_cyc(base + 16);

    // Abort in run cycle 7 (ITA): back to IDLE, no done.
    base = cyc + 1;
    start6 = 1'b1;
    push_run(0, 6, base);
    tick();
    start6 = 1'b0;
    wait_cyc(base + 6);
    abort6 = 1'b1;
    drop_after(base + 6);
    tick();
    abort6 = 1'b0;
    wait_cyc(base + 10);

    // abort alongside start while idle: start wins.
    base = cyc + 1;
    start6 = 1'b1; abort6 = 1'b1;
    push_run(0, 6, base);
    tick();
    start6 = 1'b0; abort6 = 1'b0;
    wait_cyc(base + 16);

    // Back-to-back with start held high.
    base = cyc + 1;
    start6 = 1'b1; start1 = 1'b1;
    push_run(0, 6, base);
    push_run(0, 6, base + 14);
    push_run(0, 6, base + 28);
    push_run(1, 1, base);
    push_run(1, 1, base + 4);
    push_run(1, 1, base + 8);
    tick();
    wait_cyc(base + 8);
    start1 = 1'b0;
    wait_cyc(base + 30);
    start6 = 1'b0;
    wait_cyc(base + 45);

    // Asynchronous reset mid-run at ITB with iter=3.
    base = cyc + 1;
    start6 = 1'b1;
    push_run(0, 6, base);
    tick();
    start6 = 1'b0;
    wait_cyc(base + 5);
    #1;
    check("pre_reset_itb", {3'b0, vec6}, {3'b0, mk(2'b11, 2'b01, 0, 1, 0, 1, 0, 3)});
    reset = 1'b1;
    drop_after(base + 4);
    #1;
    check("reset_mid_run", {3'b0, vec6}, 16'h0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (6) tick();

    check("q6_drained", 16'(q6.size()), 16'd0);
    check("q1_drained", 16'(q1.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
